// File: rtl/tmc_spi_pkg.sv
// tmc_spi_pkg: shared constants and types for the TMC5130 SPI slave emulator
package tmc_spi_pkg;
  localparam int FRAME_BITS = 40;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
  } tmc_cmd_t;
  typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, READ, CAPTURE} tmc_slave_state_t;
endpackage

// File: rtl/tmc_spi_slave_spi_in_sync.sv
// spi_in_sync: N-stage synchronizer with rise/fall detection on the synced value
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_vld;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  end
  // edges only count once both compared values come from post-reset samples
  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_vld[STAGES] & o_q & ~r_prev;
  assign o_fall = r_vld[STAGES] & ~o_q & r_prev;
endmodule

// File: rtl/tmc_spi_slave.sv
// tmc_spi_slave: TMC5130-style 40-bit SPI mode-3 slave decoding datagrams onto a register port
// with pipelined read-back of the previous frame's register.
module tmc_spi_slave #(
  parameter int FRAME_BITS  = tmc_spi_pkg::FRAME_BITS,
  parameter int ADDR_W      = tmc_spi_pkg::ADDR_W,
  parameter int DATA_W      = tmc_spi_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [7:0]        status_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              busy_o
);
  import tmc_spi_pkg::*;
  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
  tmc_slave_state_t r_state, w_next;
  logic [FRAME_BITS-1:0] r_rx, r_tx;
  logic [5:0] r_cnt;
  logic [DATA_W-1:0] r_rd_hold, r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic r_pend, r_we, r_re, r_done, r_err;
  logic w_sck, w_sck_rise, w_sck_fall, w_csn, w_csn_rise, w_csn_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall, w_unused;
  logic w_start, w_end, w_full;
  tmc_cmd_t w_cmd;
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck (
    .clk(pclk_i), .rst(rst_i), .i_d(spi_sck_i), .o_q(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(pclk_i), .rst(rst_i), .i_d(spi_csn_i), .o_q(w_csn), .o_rise(w_csn_rise), .o_fall(w_csn_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(pclk_i), .rst(rst_i), .i_d(spi_mosi_i), .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
  assign w_unused = ^{w_sck, w_csn, w_mosi_rise, w_mosi_fall};
  assign w_cmd    = r_rx[FRAME_BITS-1 -: 8];
  assign w_start  = (r_state == IDLE) && (w_csn_fall || r_pend);
  assign w_end    = (r_state == SHIFT) && w_csn_rise;
  assign w_full   = r_cnt == FRAME_CNT;
  always_ff @(posedge pclk_i) r_state <= rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? SHIFT : IDLE;
      SHIFT:   w_next = !w_csn_rise ? SHIFT : w_full ? COMMIT : IDLE;
      COMMIT:  w_next = READ;
      READ:    w_next = CAPTURE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      r_rx      <= '0;
      r_tx      <= '0;
      r_cnt     <= '0;
      r_rd_hold <= '0;
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pend <= (r_state inside {COMMIT, READ, CAPTURE}) && (r_pend || w_csn_fall);
      r_we   <= w_end && w_full && w_cmd.wr;
      r_re   <= r_state == COMMIT;
      r_done <= r_state == READ;
      r_err  <= w_end && !w_full;
      if (w_start) begin
        r_tx  <= {status_i, r_rd_hold};
        r_cnt <= '0;
      end
      if (r_state == SHIFT && w_sck_rise) begin
        r_rx  <= {r_rx[FRAME_BITS-2:0], w_mosi};
        r_cnt <= r_cnt + {5'd0, r_cnt != 6'd63};
      end
      // the leading SCK fall of mode 3 must keep the preloaded MSB on the line
      if (r_state == SHIFT && w_sck_fall && r_cnt != '0) r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
      if (w_end && w_full) begin
        r_addr <= w_cmd.addr;
        if (w_cmd.wr) r_wdata <= r_rx[DATA_W-1:0];
      end
      if (r_state == CAPTURE) r_rd_hold <= reg_rdata_i;
    end
  end
  assign spi_miso_oe_o = r_state == SHIFT;
  assign spi_miso_o    = spi_miso_oe_o & r_tx[FRAME_BITS-1];
  assign busy_o        = r_state != IDLE;
  assign reg_addr_o    = r_addr;
  assign reg_wdata_o   = r_wdata;
  assign reg_we_o      = r_we;
  assign reg_re_o      = r_re;
  assign frame_done_o  = r_done;
  assign frame_err_o   = r_err;
endmodule
